// File: rtl/ed25519_pkg.sv
// rtl/ed25519_pkg.sv - shared op-code/state enums and scalar width default for the scalar multiplier

package ed25519_pkg;

    // Default scalar width; bit index output is 8 bits so this must not exceed 256
    localparam int NBITS_DEF = 256;

    // Point-unit command codes
    typedef enum logic [2:0] {
        OP_INIT = 3'd0,
        OP_DBL  = 3'd1,
        OP_ADD  = 3'd2,
        OP_INV  = 3'd3,
        OP_NORM = 3'd4
    } op_code_e;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/scalar_mult_ctrl.sv
// rtl/scalar_mult_ctrl.sv - double-and-add scalar multiplication sequencer driving a point unit

module scalar_mult_ctrl
    import ed25519_pkg::*;
#(
    parameter int NBITS      = NBITS_DEF,
    parameter bit CONST_TIME = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [NBITS-1:0] i_scalar,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_op_valid,
    output logic [2:0]       o_op_code,
    output logic             o_op_real,
    input  logic             i_op_ready,
    input  logic             i_op_done,
    output logic [7:0]       o_bit_idx,
    output logic             o_err
);

    localparam logic [7:0] TOP_IDX = 8'(NBITS - 1);

    state_e           state_q, state_d;
    op_code_e         op_code_q, op_code_d;
    logic [NBITS-1:0] scalar_q, scalar_d;
    logic [7:0]       bit_idx_q, bit_idx_d;
    logic             op_valid_q, op_valid_d;
    logic             op_real_q, op_real_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             cur_bit;
    logic             next_bit;

    assign cur_bit = scalar_q[bit_idx_q];

    // Next-state and command selection; every output is a registered copy of these
    always_comb begin
        state_d    = state_q;
        op_code_d  = op_code_q;
        scalar_d   = scalar_q;
        bit_idx_d  = bit_idx_q;
        op_valid_d = op_valid_q;
        op_real_d  = op_real_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        next_bit   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    scalar_d   = i_scalar;
                    bit_idx_d  = TOP_IDX;
                    op_code_d  = OP_INIT;
                    op_real_d  = 1'b0;
                    op_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_op_done) begin
                    op_valid_d = 1'b1;
                    state_d    = S_ISSUE;
                    case (op_code_q)
                        OP_INIT: begin
                            op_code_d = OP_DBL;
                            op_real_d = 1'b0;
                        end
                        OP_DBL: begin
                            // Dummy adds keep the command stream independent of the scalar
                            if (CONST_TIME || cur_bit) begin
                                op_code_d = OP_ADD;
                                op_real_d = cur_bit;
                            end else begin
                                next_bit = 1'b1;
                            end
                        end
                        OP_ADD:  next_bit = 1'b1;
                        OP_INV: begin
                            op_code_d = OP_NORM;
                            op_real_d = 1'b0;
                        end
                        default: begin
                            op_valid_d = 1'b0;
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                            state_d    = S_DONE;
                        end
                    endcase
                    // Bit 0 finished goes straight to INV; the index never wraps
                    if (next_bit) begin
                        op_real_d = 1'b0;
                        if (bit_idx_q == 8'd0) begin
                            op_code_d = OP_INV;
                        end else begin
                            op_code_d = OP_DBL;
                            bit_idx_d = bit_idx_q - 8'd1;
                        end
                    end
                end
            end
            default: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (i_op_done && (state_q != S_WAIT)) begin
            err_d = 1'b1;
        end

        // Abort overrides any handshake or completion seen in the same cycle
        if (i_abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            op_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            op_code_q  <= OP_INIT;
            scalar_q   <= '0;
            bit_idx_q  <= 8'd0;
            op_valid_q <= 1'b0;
            op_real_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_code_q  <= op_code_d;
            scalar_q   <= scalar_d;
            bit_idx_q  <= bit_idx_d;
            op_valid_q <= op_valid_d;
            op_real_q  <= op_real_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_op_valid = op_valid_q;
    assign o_op_code  = op_code_q;
    assign o_op_real  = op_real_q;
    assign o_bit_idx  = bit_idx_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// tb/tb_scalar_mult_ctrl.sv - directed bench for scalar_mult_ctrl, constant-time and variable-time instances

module tb_scalar_mult_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start      [2];
    logic [255:0] scalar     [2];
    logic         abort_s    [2];
    logic         ready      [2];
    logic         done_r     [2];
    logic         force_done [2];
    logic         op_done    [2];
    logic         busy       [2];
    logic         done_o     [2];
    logic         valid      [2];
    logic         real_o     [2];
    logic         err        [2];
    logic [2:0]   code       [2];
    logic [7:0]   idx        [2];

    assign op_done[0] = done_r[0] | force_done[0];
    assign op_done[1] = done_r[1] | force_done[1];

    scalar_mult_ctrl #(.NBITS(256), .CONST_TIME(1'b1)) dut_ct (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_scalar(scalar[0]),
        .i_abort(abort_s[0]), .o_busy(busy[0]), .o_done(done_o[0]),
        .o_op_valid(valid[0]), .o_op_code(code[0]), .o_op_real(real_o[0]),
        .i_op_ready(ready[0]), .i_op_done(op_done[0]), .o_bit_idx(idx[0]), .o_err(err[0])
    );

    scalar_mult_ctrl #(.NBITS(256), .CONST_TIME(1'b0)) dut_nct (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_scalar(scalar[1]),
        .i_abort(abort_s[1]), .o_busy(busy[1]), .o_done(done_o[1]),
        .o_op_valid(valid[1]), .o_op_code(code[1]), .o_op_real(real_o[1]),
        .i_op_ready(ready[1]), .i_op_done(op_done[1]), .o_bit_idx(idx[1]), .o_err(err[1])
    );

    int compared;
    int mismatched;
    int pend         [2];
    int hold         [2];
    int stall_ok     [2];
    int abort_bit    [2];
    int done_cnt     [2];
    int busy_in_done [2];
    logic         rdy_v;
    logic [11:0]  entry;
    logic [11:0]  log0  [$];
    logic [11:0]  log1  [$];
    logic [11:0]  exp_q [$];

    // Point-unit model: accepts commands, answers 3 cycles after acceptance, logs every command
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            done_r[k]  = 1'b0;
            abort_s[k] = 1'b0;
            if (!rst_n) begin
                pend[k]  = 0;
                ready[k] = 1'b1;
            end else begin
                if (done_o[k]) begin
                    done_cnt[k]++;
                    if (busy[k]) busy_in_done[k]++;
                end
                if (pend[k] > 0) begin
                    pend[k]--;
                    if (pend[k] == 0) begin
                        done_r[k] = 1'b1;
                        if (abort_bit[k] >= 0 && int'(idx[k]) == abort_bit[k]) begin
                            abort_s[k]   = 1'b1;
                            abort_bit[k] = -1;
                        end
                    end
                end
                rdy_v = 1'b1;
                if (hold[k] > 0 && valid[k] && code[k] == 3'd1) begin
                    rdy_v = 1'b0;
                    hold[k]--;
                    if (idx[k] == 8'd255) stall_ok[k]++;
                end
                ready[k] = rdy_v;
                if (valid[k] && rdy_v) begin
                    entry = {code[k], real_o[k], idx[k]};
                    if (k == 0) log0.push_back(entry);
                    else        log1.push_back(entry);
                    pend[k] = 3;
                end
            end
        end
    end

    task automatic build_exp(input bit ct, input logic [255:0] s);
        exp_q.delete();
        exp_q.push_back({3'd0, 1'b0, 8'd255});
        for (int b = 255; b >= 0; b--) begin
            exp_q.push_back({3'd1, 1'b0, 8'(b)});
            if (ct || s[b]) exp_q.push_back({3'd2, s[b], 8'(b)});
        end
        exp_q.push_back({3'd3, 1'b0, 8'd0});
        exp_q.push_back({3'd4, 1'b0, 8'd0});
    endtask

    function automatic int diff_log(input int k);
        int n = 0;
        int sz;
        sz = (k == 0) ? log0.size() : log1.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= sz) n++;
            else if (((k == 0) ? log0[i] : log1[i]) !== exp_q[i]) n++;
        end
        if (sz > exp_q.size()) n += sz - exp_q.size();
        return n;
    endfunction

    task automatic start_job(input int k, input logic [255:0] s);
        scalar[k] = s;
        start[k]  = 1'b1;
        @(negedge clk);
        start[k]  = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done_o[k]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            compared++;
            if ({busy[k], done_o[k], valid[k], real_o[k], err[k]} !== 5'b0) begin
                mismatched++;
                $display("FAIL reset_flags[%0d]: got %b expected 00000", k, {busy[k], done_o[k], valid[k], real_o[k], err[k]});
            end
            compared++;
            if (code[k] !== 3'd0) begin
                mismatched++;
                $display("FAIL reset_code[%0d]: got %0d expected 0", k, code[k]);
            end
            compared++;
            if (idx[k] !== 8'd0) begin
                mismatched++;
                $display("FAIL reset_idx[%0d]: got %0d expected 0", k, idx[k]);
            end
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ct_scalar_one();
        bit ok;
        int reals;
        log0.delete();
        done_cnt[0] = 0; busy_in_done[0] = 0; stall_ok[0] = 0; hold[0] = 10;
        start_job(0, 256'd1);
        compared++;
        if ({busy[0], valid[0], code[0], idx[0]} !== {1'b1, 1'b1, 3'd0, 8'd255}) begin
            mismatched++;
            $display("FAIL ct_first_issue: got busy=%b valid=%b code=%0d idx=%0d expected 1 1 0 255", busy[0], valid[0], code[0], idx[0]);
        end
        wait_done(0, 6000, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL ct_done_timeout: got no done expected done within 6000 cycles");
        end
        compared++;
        if (busy[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL ct_busy_at_done: got %b expected 0", busy[0]);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (log0.size() != 515) begin
            mismatched++;
            $display("FAIL ct_cmd_count: got %0d expected 515", log0.size());
        end
        build_exp(1'b1, 256'd1);
        compared++;
        if (diff_log(0) != 0) begin
            mismatched++;
            $display("FAIL ct_sequence: got %0d differing commands expected 0", diff_log(0));
        end
        reals = 0;
        foreach (log0[i]) if (log0[i][8]) reals++;
        compared++;
        if (reals != 1) begin
            mismatched++;
            $display("FAIL ct_real_adds: got %0d expected 1", reals);
        end
        compared++;
        if (done_cnt[0] != 1 || busy_in_done[0] != 0) begin
            mismatched++;
            $display("FAIL ct_done_pulse: got count=%0d busy_in_done=%0d expected 1 0", done_cnt[0], busy_in_done[0]);
        end
        compared++;
        if (stall_ok[0] != 10) begin
            mismatched++;
            $display("FAIL stall_stable: got %0d stable stall cycles expected 10", stall_ok[0]);
        end
    endtask

    task automatic test_nct_patterns();
        bit ok;
        int reals;
        log1.delete();
        start_job(1, {256{1'b1}});
        wait_done(1, 6000, ok);
        repeat (2) @(negedge clk);
        compared++;
        if (!ok || log1.size() != 515) begin
            mismatched++;
            $display("FAIL nct_ones_count: got done=%0d count=%0d expected 1 515", ok, log1.size());
        end
        build_exp(1'b0, {256{1'b1}});
        reals = 0;
        foreach (log1[i]) if (log1[i][8]) reals++;
        compared++;
        if (diff_log(1) != 0 || reals != 256) begin
            mismatched++;
            $display("FAIL nct_ones_seq: got %0d diffs %0d real adds expected 0 256", diff_log(1), reals);
        end
        log1.delete();
        start_job(1, 256'd0);
        wait_done(1, 6000, ok);
        repeat (2) @(negedge clk);
        compared++;
        if (!ok || log1.size() != 259) begin
            mismatched++;
            $display("FAIL nct_zero_count: got done=%0d count=%0d expected 1 259", ok, log1.size());
        end
        build_exp(1'b0, 256'd0);
        compared++;
        if (diff_log(1) != 0) begin
            mismatched++;
            $display("FAIL nct_zero_seq: got %0d differing commands expected 0", diff_log(1));
        end
    endtask

    task automatic test_abort();
        bit found;
        int sz;
        log0.delete();
        done_cnt[0] = 0;
        abort_bit[0] = 200;
        start_job(0, {8{32'hA5C3_0F96}});
        found = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!busy[0]) begin
                found = 1'b1;
                break;
            end
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL abort_timeout: got busy still high expected busy low after abort");
        end
        compared++;
        if ({valid[0], done_o[0]} !== 2'b00) begin
            mismatched++;
            $display("FAIL abort_outputs: got valid=%b done=%b expected 0 0", valid[0], done_o[0]);
        end
        sz = log0.size();
        compared++;
        if (sz != 112) begin
            mismatched++;
            $display("FAIL abort_cmd_count: got %0d expected 112", sz);
        end
        repeat (30) @(negedge clk);
        compared++;
        if (log0.size() != sz || done_cnt[0] != 0 || busy[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_quiet: got count=%0d dones=%0d busy=%b expected %0d 0 0", log0.size(), done_cnt[0], busy[0], sz);
        end
        abort_bit[0] = -1;
    endtask

    task automatic test_protocol();
        bit ok;
        force_done[1] = 1'b1;
        @(negedge clk);
        force_done[1] = 1'b0;
        compared++;
        if (err[1] !== 1'b1) begin
            mismatched++;
            $display("FAIL err_set: got %b expected 1", err[1]);
        end
        repeat (5) @(negedge clk);
        compared++;
        if (err[1] !== 1'b1) begin
            mismatched++;
            $display("FAIL err_sticky: got %b expected 1", err[1]);
        end
        log1.delete();
        start_job(1, 256'd0);
        compared++;
        if (err[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL err_clear_on_start: got %b expected 0", err[1]);
        end
        repeat (20) @(negedge clk);
        scalar[1] = {256{1'b1}};
        start[1]  = 1'b1;
        @(negedge clk);
        start[1]  = 1'b0;
        wait_done(1, 6000, ok);
        repeat (2) @(negedge clk);
        build_exp(1'b0, 256'd0);
        compared++;
        if (!ok || log1.size() != 259 || diff_log(1) != 0) begin
            mismatched++;
            $display("FAIL busy_start_ignored: got done=%0d count=%0d diffs=%0d expected 1 259 0", ok, log1.size(), diff_log(1));
        end
    endtask

    task automatic test_reset_mid_inv();
        bit found;
        bit ok;
        log0.delete();
        done_cnt[0] = 0;
        start_job(0, 256'd5);
        found = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (valid[0] && code[0] == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL inv_timeout: got no INV issue expected INV issued");
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({busy[0], done_o[0], valid[0], real_o[0], err[0], code[0], idx[0]} !== 16'd0) begin
            mismatched++;
            $display("FAIL async_reset: got busy=%b done=%b valid=%b real=%b err=%b code=%0d idx=%0d expected all 0",
                     busy[0], done_o[0], valid[0], real_o[0], err[0], code[0], idx[0]);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (done_cnt[0] != 0) begin
            mismatched++;
            $display("FAIL reset_no_done: got %0d expected 0", done_cnt[0]);
        end
        log0.delete();
        start_job(0, 256'd1);
        wait_done(0, 6000, ok);
        repeat (2) @(negedge clk);
        build_exp(1'b1, 256'd1);
        compared++;
        if (!ok || diff_log(0) != 0 || done_cnt[0] != 1) begin
            mismatched++;
            $display("FAIL restart_after_reset: got done=%0d diffs=%0d dones=%0d expected 1 0 1", ok, diff_log(0), done_cnt[0]);
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; scalar[k] = '0; abort_s[k] = 1'b0; ready[k] = 1'b1;
            done_r[k] = 1'b0; force_done[k] = 1'b0; pend[k] = 0; hold[k] = 0;
            stall_ok[k] = 0; abort_bit[k] = -1; done_cnt[k] = 0; busy_in_done[k] = 0;
        end
        test_reset();
        test_ct_scalar_one();
        test_nct_patterns();
        test_abort();
        test_protocol();
        test_reset_mid_inv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
